// File: rtl/sap_core_param.sv
// Parametrised SAP-style accumulator CPU with carry/zero flags, branches and a program-load port.
// Every instruction takes one FETCH and one EXEC cycle; ena freezes all state including RAM.
module sap_core_param #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              run,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              halted,
    output logic              busy,
    output logic [ADDR_W-1:0] pc
);

    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_EXEC  = 2'd2;
    localparam logic [1:0] S_HALT  = 2'd3;

    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [3:0]        r_ir_op;
    logic [ADDR_W-1:0] r_ir_arg;
    logic              r_c;
    logic              r_z;
    logic [DATA_W-1:0] r_out;
    logic              r_out_vld;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_loadable;
    logic              w_prog_wr;
    logic              w_sta_wr;
    logic              w_is_sub;
    logic [DATA_W-1:0] w_mem_op;
    logic [DATA_W-1:0] w_alu_b;
    logic [DATA_W:0]   w_alu;

    // Only the opcode and operand fields of IR are kept; the middle bits are don't-care.
    assign w_loadable = (r_state == S_IDLE) || (r_state == S_HALT);
    assign w_prog_wr  = ena && w_loadable && prog_we;
    assign w_sta_wr   = ena && (r_state == S_EXEC) && (r_ir_op == OP_STA);
    assign w_mem_op   = r_mem[r_ir_arg];
    assign w_is_sub   = (r_ir_op == OP_SUB);
    assign w_alu_b    = w_is_sub ? ~w_mem_op : w_mem_op;
    assign w_alu      = {1'b0, r_a} + {1'b0, w_alu_b} + (DATA_W+1)'(w_is_sub);

    always_ff @(posedge clk) begin
        if (w_prog_wr)
            r_mem[prog_addr] <= prog_data;
        else if (w_sta_wr)
            r_mem[r_ir_arg] <= r_a;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_pc      <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_ir_op   <= '0;
            r_ir_arg  <= '0;
            r_c       <= 1'b0;
            r_z       <= 1'b0;
            r_out     <= '0;
            r_out_vld <= 1'b0;
        end else if (ena) begin
            r_out_vld <= 1'b0;
            case (r_state)
                S_IDLE, S_HALT: begin
                    if (run) begin
                        r_state <= S_FETCH;
                        r_pc    <= '0;
                        r_a     <= '0;
                        r_b     <= '0;
                        r_c     <= 1'b0;
                        r_z     <= 1'b0;
                    end
                end
                S_FETCH: begin
                    r_ir_op  <= r_mem[r_pc][DATA_W-1 -: 4];
                    r_ir_arg <= r_mem[r_pc][ADDR_W-1:0];
                    r_pc     <= r_pc + ADDR_W'(1);
                    r_state  <= S_EXEC;
                end
                S_EXEC: begin
                    r_state <= S_FETCH;
                    case (r_ir_op)
                        OP_LDA: r_a <= w_mem_op;
                        OP_ADD, OP_SUB: begin
                            r_b <= w_mem_op;
                            r_a <= w_alu[DATA_W-1:0];
                            r_c <= w_alu[DATA_W];
                            r_z <= (w_alu[DATA_W-1:0] == '0);
                        end
                        OP_LDI: r_a <= {{(DATA_W-ADDR_W){1'b0}}, r_ir_arg};
                        OP_JMP: r_pc <= r_ir_arg;
                        OP_JC:  if (r_c) r_pc <= r_ir_arg;
                        OP_JZ:  if (r_z) r_pc <= r_ir_arg;
                        OP_OUT: begin
                            r_out     <= r_a;
                            r_out_vld <= 1'b1;
                        end
                        OP_HLT: r_state <= S_HALT;
                        default: ;
                    endcase
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign out_data  = r_out;
    assign out_valid = r_out_vld;
    assign halted    = (r_state == S_HALT);
    assign busy      = (r_state == S_FETCH) || (r_state == S_EXEC);
    assign pc        = r_pc;

endmodule

// File: tb/tb_sap_core_param.sv
// Directed bench for sap_core_param: programs are loaded through the load port, expected OUT
// values and their edge numbers go into a scoreboard that a negedge monitor drains.
module tb_sap_core_param;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;

    logic              clk, rst_n, ena, run, prog_we;
    logic [ADDR_W-1:0] prog_addr;
    logic [DATA_W-1:0] prog_data;
    logic [DATA_W-1:0] out_data;
    logic              out_valid, halted, busy;
    logic [ADDR_W-1:0] pc;

    sap_core_param #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .run(run), .prog_we(prog_we),
        .prog_addr(prog_addr), .prog_data(prog_data), .out_data(out_data),
        .out_valid(out_valid), .halted(halted), .busy(busy), .pc(pc)
    );

    typedef struct {
        logic [7:0] data;
        int         at;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         k;
    logic [7:0] img [16];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Every OUT pulse must match the head of the scoreboard, both value and edge number.
    always @(negedge clk) begin
        if (out_valid) begin
            if (sb.size() == 0) chk("spurious_valid", {31'd0, out_valid}, 32'd0);
            else begin
                exp_t e;
                e = sb.pop_front();
                chk("out_data", {24'd0, out_data}, {24'd0, e.data});
                chk("out_edge", cyc, e.at);
            end
        end
    end

    task automatic expect_out(input logic [7:0] d, input int at);
        exp_t e;
        e.data = d;
        e.at   = at;
        sb.push_back(e);
    endtask

    task automatic load(input logic [3:0] a, input logic [7:0] d);
        prog_we = 1'b1; prog_addr = a; prog_data = d;
        @(negedge clk);
        prog_we = 1'b0;
    endtask

    task automatic load_img();
        for (int i = 0; i < 16; i++) load(4'(i), img[i]);
    endtask

    task automatic start(output int kk);
        run = 1'b1;
        kk  = cyc + 1;
        @(negedge clk);
        run = 1'b0;
    endtask

    task automatic wait_halt(input string tag, input int exp_edge);
        int n = 0;
        while (!halted && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(tag, cyc, exp_edge);
        chk({tag, "_sb_empty"}, sb.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        clk = 0; rst_n = 0; ena = 1; run = 0; prog_we = 0; prog_addr = '0; prog_data = '0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        chk("rst_out_data", {24'd0, out_data}, 0);
        chk("rst_out_valid", {31'd0, out_valid}, 0);
        chk("rst_halted", {31'd0, halted}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_pc", {28'd0, pc}, 0);
        repeat (10) @(negedge clk);
        chk("idle_busy", {31'd0, busy}, 0);
        chk("idle_pc", {28'd0, pc}, 0);
        chk("idle_halted", {31'd0, halted}, 0);

        // Basic: 28 + 14 = 42
        img = '{8'h1E, 8'h2F, 8'hE0, 8'hF0, 8'h00, 8'h00, 8'h00, 8'h00,
                8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'd28, 8'd14};
        load_img();
        start(k);
        expect_out(8'd42, k + 6);
        chk("basic_busy", {31'd0, busy}, 1);
        wait_halt("basic_halt", k + 8);
        chk("basic_pc", {28'd0, pc}, 4);

        // prog_we while busy must not disturb the program or its data
        start(k);
        expect_out(8'd42, k + 6);
        for (int i = 0; i < 6; i++) begin
            prog_we = 1'b1; prog_addr = 4'(14 + (i % 2)); prog_data = 8'h00;
            @(negedge clk);
        end
        prog_we = 1'b0;
        wait_halt("busywe_halt", k + 8);
        start(k);
        expect_out(8'd42, k + 6);
        wait_halt("busywe_rerun", k + 8);

        // ena low for 5 cycles after the LDA: everything shifts by 5 edges
        start(k);
        expect_out(8'd42, k + 11);
        @(negedge clk);
        ena = 1'b0;
        repeat (5) @(negedge clk);
        chk("ena_pc_frozen", {28'd0, pc}, 1);
        ena = 1'b1;
        wait_halt("ena_halt", k + 13);

        // Reset during EXEC of ADD, then rerun from the preserved RAM
        start(k);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", {31'd0, busy}, 0);
        chk("midrst_pc", {28'd0, pc}, 0);
        chk("midrst_out", {24'd0, out_data}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start(k);
        expect_out(8'd42, k + 6);
        wait_halt("midrst_rerun", k + 8);

        // Flags and branches: 5-5 takes JZ and JC; 5-6 takes neither
        img = '{8'h55, 8'h3F, 8'h88, 8'hE0, 8'h7B, 8'h52, 8'hE0, 8'hF0,
                8'hE0, 8'h7B, 8'hF0, 8'h51, 8'hE0, 8'hF0, 8'h00, 8'h05};
        load_img();
        start(k);
        expect_out(8'h00, k + 8);
        expect_out(8'h01, k + 14);
        wait_halt("sub_eq_halt", k + 16);
        load(4'hF, 8'h06);
        start(k);
        expect_out(8'hFF, k + 8);
        expect_out(8'h02, k + 14);
        wait_halt("sub_lt_halt", k + 16);

        // Carry: 0xF0 + 0x20 = 0x10 with C=1, JC taken
        img = '{8'h1E, 8'h2F, 8'hE0, 8'h75, 8'hF0, 8'h57, 8'hE0, 8'hF0,
                8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hF0, 8'h20};
        load_img();
        start(k);
        expect_out(8'h10, k + 6);
        expect_out(8'h07, k + 12);
        wait_halt("carry_halt", k + 14);

        // PC wrap: NOPs through address 15, then JC back to a HLT at address 2
        img = '{8'h72, 8'h63, 8'hF0, 8'h1F, 8'h2F, 8'hE0, 8'h00, 8'h00,
                8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h90};
        load_img();
        start(k);
        expect_out(8'h20, k + 10);
        wait_halt("wrap_halt", k + 34);
        chk("wrap_pc", {28'd0, pc}, 3);

        // STA into a code word (becomes NOP 0x0F), then STA/LDA round trip
        img = '{8'h5F, 8'h43, 8'h00, 8'h00, 8'hE0, 8'h59, 8'h4D, 8'h50,
                8'h1D, 8'hE0, 8'hF0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        load_img();
        start(k);
        expect_out(8'h0F, k + 10);
        expect_out(8'h09, k + 20);
        wait_halt("sta_halt", k + 22);

        // STA overwrites the very next instruction (HLT -> OUT)
        img = '{8'h1E, 8'h42, 8'hF0, 8'hF0, 8'h00, 8'h00, 8'h00, 8'h00,
                8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hE0, 8'h00};
        load_img();
        start(k);
        expect_out(8'hE0, k + 6);
        wait_halt("selfmod_halt", k + 8);

        // prog_we and run in the same cycle: first fetch sees the new word
        load(4'h0, 8'hF0);
        load(4'h1, 8'hF0);
        prog_we = 1'b1; prog_addr = 4'h0; prog_data = 8'hE0;
        start(k);
        prog_we = 1'b0;
        expect_out(8'h00, k + 2);
        wait_halt("samecyc_halt", k + 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sap_core_param.md
Name: sap_core_param

Overview:
Parametrised successor of the fixed 8-bit SAP-1 core: accumulator CPU with generic data width and address/RAM depth. Adds an extended instruction set (SUB, STA, LDI, JMP, JC, JZ), carry and zero flags, and a program-load port. Sits inside the TinyTapeout top wrapper. The wrapper maps ui_in/uio_in to the load port and run/ena controls, and maps out_data to uo_out.

Parameters:
DATA_W, 8, datapath and RAM word width; must be >= ADDR_W+4
ADDR_W, 4, address width; RAM depth = 2**ADDR_W words

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
ena  in  1  clock enable; low freezes all state, RAM included
run  in  1  start/restart pulse, sampled in IDLE or HALT
prog_we  in  1  program-RAM write strobe
prog_addr  in  ADDR_W  program write address
prog_data  in  DATA_W  program write data
out_data  out  DATA_W  output register (OUT instruction)
out_valid  out  1  one-cycle pulse when out_data updates
halted  out  1  high while in HALT
busy  out  1  high in FETCH or EXEC
pc  out  ADDR_W  current program counter (debug)

Behaviour:
- Reset (async assert, released on clock edge): state=IDLE, pc=0, A=0, B=0, IR=0, C=0, Z=0, out_data=0, out_valid=0, halted=0, busy=0. RAM is not cleared and keeps its contents.
- Instruction format: opcode = IR[DATA_W-1:DATA_W-4]; operand = IR[ADDR_W-1:0]. The bits in between are ignored.
- Opcodes:
  - 0 NOP
  - 1 LDA: A=M[op]
  - 2 ADD: B=M[op]; A=A+B
  - 3 SUB: B=M[op]; A=A+~B+1
  - 4 STA: M[op]=A
  - 5 LDI: A=zero-extended op
  - 6 JMP: pc=op
  - 7 JC: if C then pc=op
  - 8 JZ: if Z then pc=op
  - E OUT: out_data=A, out_valid=1
  - F HLT
  - 9-D execute as NOP.
- RAM: array of 2**ADDR_W x DATA_W, combinational read, synchronous write.
- States:
  - IDLE: prog_we writes M[prog_addr]=prog_data. run=1 -> FETCH, with pc=0, A=0, B=0, C=0, Z=0.
  - FETCH: IR=M[pc]; pc=pc+1, modulo 2**ADDR_W (wraps from max to 0); -> EXEC.
  - EXEC: executes IR in one cycle. HLT -> HALT; all others -> FETCH.
  - HALT: halted=1. prog_we is accepted as in IDLE. run=1 -> FETCH with the same register clear as from IDLE. RAM is preserved.
- Timing: every instruction takes exactly 2 enabled cycles.
  - If run is sampled at edge k, the first instruction fetches at k+1 and executes at k+2.
  - out_valid is high for exactly the one cycle following the EXEC edge of OUT. out_data holds its value until the next OUT or reset.
- Flags: updated only by ADD/SUB.
  - C = carry out of bit DATA_W-1. For SUB, C=1 means no borrow (A>=B).
  - Z = (result == 0).
  - A wraps modulo 2**DATA_W.
- prog_we in FETCH/EXEC is ignored; no write occurs.
- run in FETCH/EXEC is ignored.
- prog_we and run in the same IDLE cycle: the write completes and execution starts; the first fetch sees the written word.
- Self-modifying code: an STA into the next instruction's address takes effect on the following FETCH.
- ena=0: no register or RAM updates; out_valid holds its level. Resumes from the exact cycle when ena returns high.
- Reset asserted mid-instruction: immediate return to IDLE, all outputs at reset values, any partial instruction discarded.

Test Plan:
- Reset/idle (DATA_W=8, ADDR_W=4): after reset, outputs = 0, busy=0, halted=0. run=0 for 10 cycles -> no change.
- Basic program: load M0=0x1E (LDA E), M1=0x2F (ADD F), M2=0xE0 (OUT), M3=0xF0 (HLT), ME=28, MF=14; pulse run at edge k -> out_data=42 and out_valid high for one cycle after edge k+6; halted=1 after edge k+8.
- Flags/branches: LDI 5; SUB M[F]=5 -> Z=1, C=1; JZ to 8; the OUT at address 8 emits 0. Repeat with M[F]=6 -> A=0xFF, C=0, Z=0, branch not taken.
- Wrap/carry: A=0xF0 ADD 0x20 -> A=0x10, C=1. Program with NOPs through address 15 and no HLT -> pc wraps to 0 and execution continues.
- STA/self-modify: LDI 0xF (A=0x0F); STA 3, with M3 initially NOP -> at address 3 the core executes opcode 0 operand F (NOP) without hanging. Separately, STA to a data word followed by LDA of it returns the same value.
- Control corners:
  - prog_we during busy -> RAM unchanged.
  - ena low for 5 cycles mid-program -> output timing shifts by exactly 5 cycles.
  - rst_n low during EXEC of ADD -> immediate IDLE, A=0; RAM still holds the program; rerun gives 42.
